// File: rtl/multicycle_control_if.sv
// rtl/multicycle_control_if.sv - shared memory port handshake between control FSM and memory
interface multicycle_control_if;
    logic mem_req;
    logic mem_we;
    logic mem_ready;

    modport master (
        output mem_req,
        output mem_we,
        input  mem_ready
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        output mem_ready
    );
endinterface

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - femtoRV32 multi-cycle main control FSM (optional halt: MC_HALT_EN)
module multicycle_control #(
    parameter int STALL_CNT_W = 8,
    parameter int INSN_CNT_W  = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    multicycle_control_if.master  bus,
    input  logic [4:0]            opcode,
    input  logic                  branch_taken,
    output logic                  ir_we,
    output logic                  pc_we,
    output logic [1:0]            pc_src,
    output logic [1:0]            alu_op,
    output logic                  alu_src,
    output logic                  reg_write,
    output logic [1:0]            wb_sel,
    output logic [2:0]            state,
    output logic                  mem_timeout,
    output logic [INSN_CNT_W-1:0] retired,
    output logic                  halted
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    localparam logic [4:0] OP_R      = 5'b01100;
    localparam logic [4:0] OP_I      = 5'b00100;
    localparam logic [4:0] OP_LOAD   = 5'b00000;
    localparam logic [4:0] OP_STORE  = 5'b01000;
    localparam logic [4:0] OP_BRANCH = 5'b11000;
    localparam logic [4:0] OP_LUI    = 5'b01101;
    localparam logic [4:0] OP_AUIPC  = 5'b00101;
    localparam logic [4:0] OP_JAL    = 5'b11011;
    localparam logic [4:0] OP_JALR   = 5'b11001;
    localparam logic [4:0] OP_SYSTEM = 5'b11100;

    localparam logic [STALL_CNT_W-1:0] WD_MAX = '1;
    localparam logic [INSN_CNT_W-1:0]  ONE    = 1;

    state_t                 state_q, state_d;
    logic [4:0]             op_q;
    logic [STALL_CNT_W-1:0] wd_q, wd_d;

    logic req_r, we_r, ir_we_r, pc_we_r, alu_src_r, reg_write_r;
    logic [1:0] pc_src_r, alu_op_r, wb_sel_r;
    logic mem_wait_state, mem_enter;

    // State register, latched opcode, watchdog and retire counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_FETCH;
            op_q        <= 5'd0;
            wd_q        <= '0;
            mem_timeout <= 1'b0;
            retired     <= '0;
        end else begin
            state_q <= state_d;
            wd_q    <= wd_d;
            if (state_q == S_DECODE)
                op_q <= opcode;
            if (wd_d == WD_MAX)
                mem_timeout <= 1'b1;
            if (pc_we_r)
                retired <= retired + ONE;
        end
    end

    // Next state and raw strobes decoded from state and the latched opcode
    always_comb begin
        state_d     = state_q;
        req_r       = 1'b0;
        we_r        = 1'b0;
        ir_we_r     = 1'b0;
        pc_we_r     = 1'b0;
        pc_src_r    = 2'b00;
        alu_op_r    = 2'b00;
        alu_src_r   = 1'b0;
        reg_write_r = 1'b0;
        wb_sel_r    = 2'b00;
        case (state_q)
            S_FETCH: begin
                req_r = 1'b1;
                if (bus.mem_ready) begin
                    ir_we_r = 1'b1;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                state_d = S_EXEC;
`ifdef MC_HALT_EN
                if (opcode == OP_SYSTEM)
                    state_d = S_HALT;
`endif
            end
            S_EXEC: begin
                state_d = S_FETCH;
                case (op_q)
                    OP_R: begin
                        alu_op_r = 2'b10;
                        state_d  = S_WB;
                    end
                    OP_I: begin
                        alu_op_r  = 2'b10;
                        alu_src_r = 1'b1;
                        state_d   = S_WB;
                    end
                    OP_LUI, OP_AUIPC: begin
                        alu_src_r = 1'b1;
                        state_d   = S_WB;
                    end
                    OP_LOAD, OP_STORE: begin
                        alu_src_r = 1'b1;
                        state_d   = S_MEM;
                    end
                    OP_BRANCH: begin
                        alu_op_r = 2'b01;
                        pc_we_r  = 1'b1;
                        pc_src_r = branch_taken ? 2'b01 : 2'b00;
                    end
                    OP_JAL: begin
                        pc_we_r     = 1'b1;
                        pc_src_r    = 2'b01;
                        reg_write_r = 1'b1;
                        wb_sel_r    = 2'b10;
                    end
                    OP_JALR: begin
                        alu_src_r   = 1'b1;
                        pc_we_r     = 1'b1;
                        pc_src_r    = 2'b10;
                        reg_write_r = 1'b1;
                        wb_sel_r    = 2'b10;
                    end
                    default: pc_we_r = 1'b1;  // FENCE, SYSTEM, undefined: retire as NOP
                endcase
            end
            S_MEM: begin
                req_r     = 1'b1;
                we_r      = (op_q == OP_STORE);
                alu_src_r = 1'b1;
                if (bus.mem_ready) begin
                    if (op_q == OP_STORE) begin
                        pc_we_r = 1'b1;
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_WB;
                    end
                end
            end
            S_WB: begin
                reg_write_r = 1'b1;
                wb_sel_r    = (op_q == OP_LOAD) ? 2'b01 : 2'b00;
                pc_we_r     = 1'b1;
                state_d     = S_FETCH;
            end
`ifdef MC_HALT_EN
            S_HALT: state_d = S_HALT;
`endif
            default: state_d = S_FETCH;
        endcase
    end

    // Watchdog next value: restart on each new access or completion, else count up and saturate
    always_comb begin
        mem_wait_state = (state_q == S_FETCH) || (state_q == S_MEM);
        mem_enter      = ((state_d == S_FETCH) || (state_d == S_MEM)) && (state_d != state_q);
        wd_d           = wd_q;
        if (mem_enter || (mem_wait_state && bus.mem_ready))
            wd_d = '0;
        else if (mem_wait_state && (wd_q != WD_MAX))
            wd_d = wd_q + 1'b1;
    end

    // Strobes are held low for the whole time reset is asserted
    always_comb begin
        bus.mem_req = req_r & ~rst;
        bus.mem_we  = we_r & ~rst;
        ir_we       = ir_we_r & ~rst;
        pc_we       = pc_we_r & ~rst;
        pc_src      = rst ? 2'b00 : pc_src_r;
        alu_op      = rst ? 2'b00 : alu_op_r;
        alu_src     = alu_src_r & ~rst;
        reg_write   = reg_write_r & ~rst;
        wb_sel      = rst ? 2'b00 : wb_sel_r;
        state       = state_q;
`ifdef MC_HALT_EN
        halted      = (state_q == S_HALT);
`else
        halted      = 1'b0;
`endif
    end

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - randomized self-checking bench for multicycle_control
module tb_multicycle_control;

    localparam int SW    = 4;
    localparam int WDMAX = (1 << SW) - 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [4:0]  opcode = 5'd0;
    logic        branch_taken = 1'b0;
    logic        ir_we, pc_we, alu_src, reg_write, mem_timeout, halted;
    logic [1:0]  pc_src, alu_op, wb_sel;
    logic [2:0]  state;
    logic [31:0] retired;

    multicycle_control_if bus ();

    multicycle_control #(.STALL_CNT_W(SW), .INSN_CNT_W(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .opcode       (opcode),
        .branch_taken (branch_taken),
        .ir_we        (ir_we),
        .pc_we        (pc_we),
        .pc_src       (pc_src),
        .alu_op       (alu_op),
        .alu_src      (alu_src),
        .reg_write    (reg_write),
        .wb_sel       (wb_sel),
        .state        (state),
        .mem_timeout  (mem_timeout),
        .retired      (retired),
        .halted       (halted)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] st;
        logic       req;
        logic       we;
        logic       irwe;
        logic       pcwe;
        logic [1:0] pcsrc;
        logic [1:0] aluop;
        logic       alusrc;
        logic       regw;
        logic [1:0] wbsel;
        logic       to;
        logic       hlt;
        logic       rdy;
    } step_t;

    typedef enum int {C_R, C_I, C_UI, C_LD, C_ST, C_BR, C_JAL, C_JALR, C_NOP, C_SYS} cls_t;

    step_t       trace[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] ref_retired = 0;
    logic        ref_sticky = 0;
    logic [4:0]  op_table [11] = '{5'b01100, 5'b00100, 5'b00000, 5'b01000, 5'b11000,
                                   5'b01101, 5'b00101, 5'b11011, 5'b11001, 5'b11100, 5'b00011};

    task automatic check(input string tag, input logic [31:0] o, input logic [31:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
        end
    endtask

    function automatic cls_t classify(input logic [4:0] op);
        case (op)
            5'b01100: return C_R;
            5'b00100: return C_I;
            5'b01101, 5'b00101: return C_UI;
            5'b00000: return C_LD;
            5'b01000: return C_ST;
            5'b11000: return C_BR;
            5'b11011: return C_JAL;
            5'b11001: return C_JALR;
`ifdef MC_HALT_EN
            5'b11100: return C_SYS;
`endif
            default:  return C_NOP;
        endcase
    endfunction

    function automatic logic [16:0] observed();
        return {state, bus.mem_req, bus.mem_we, ir_we, pc_we, pc_src, alu_op,
                alu_src, reg_write, wb_sel, mem_timeout, halted};
    endfunction

    // Expected per-cycle trace of one instruction, from the instruction's class and its wait counts
    task automatic build(input logic [4:0] op, input int fw, input int mw, input logic taken);
        cls_t  c = classify(op);
        step_t s;
        trace.delete();
        for (int i = 0; i <= fw; i++) begin
            s = '0; s.st = 3'd0; s.req = 1'b1; s.rdy = (i == fw); s.irwe = (i == fw);
            s.to = ref_sticky || (i >= WDMAX);
            trace.push_back(s);
        end
        if (fw >= WDMAX) ref_sticky = 1'b1;
        s = '0; s.st = 3'd1; s.to = ref_sticky; s.rdy = 1'($urandom_range(0, 1));
        trace.push_back(s);
        if (c == C_SYS) begin
            for (int i = 0; i < 3; i++) begin
                s = '0; s.st = 3'd5; s.hlt = 1'b1; s.to = ref_sticky; s.rdy = 1'($urandom_range(0, 1));
                trace.push_back(s);
            end
            return;
        end
        s = '0; s.st = 3'd2; s.to = ref_sticky; s.rdy = 1'($urandom_range(0, 1));
        case (c)
            C_R:    s.aluop = 2'b10;
            C_I:    begin s.aluop = 2'b10; s.alusrc = 1'b1; end
            C_UI, C_LD, C_ST: s.alusrc = 1'b1;
            C_BR:   begin s.aluop = 2'b01; s.pcwe = 1'b1; s.pcsrc = taken ? 2'b01 : 2'b00; end
            C_JAL:  begin s.pcwe = 1'b1; s.pcsrc = 2'b01; s.regw = 1'b1; s.wbsel = 2'b10; end
            C_JALR: begin s.alusrc = 1'b1; s.pcwe = 1'b1; s.pcsrc = 2'b10; s.regw = 1'b1; s.wbsel = 2'b10; end
            default: s.pcwe = 1'b1;
        endcase
        trace.push_back(s);
        if (c == C_LD || c == C_ST) begin
            for (int i = 0; i <= mw; i++) begin
                s = '0; s.st = 3'd3; s.req = 1'b1; s.we = (c == C_ST); s.alusrc = 1'b1;
                s.rdy = (i == mw); s.pcwe = (c == C_ST) && (i == mw);
                s.to = ref_sticky || (i >= WDMAX);
                trace.push_back(s);
            end
            if (mw >= WDMAX) ref_sticky = 1'b1;
        end
        if (c == C_R || c == C_I || c == C_UI || c == C_LD) begin
            s = '0; s.st = 3'd4; s.regw = 1'b1; s.wbsel = (c == C_LD) ? 2'b01 : 2'b00;
            s.pcwe = 1'b1; s.to = ref_sticky; s.rdy = 1'($urandom_range(0, 1));
            trace.push_back(s);
        end
        ref_retired = ref_retired + 1;
    endtask

    task automatic run(input int n);
        step_t s;
        for (int k = 0; k < n; k++) begin
            s = trace[k];
            bus.mem_ready = s.rdy;
            #1;
            check($sformatf("step%0d_op%b", k, opcode), 32'(observed()), 32'(s[17:1]));
            @(posedge clk);
            #1;
        end
    endtask

    task automatic insn(input logic [4:0] op, input int fw, input int mw, input logic taken);
        opcode = op;
        branch_taken = taken;
        build(op, fw, mw, taken);
        run(trace.size());
        check("retired", retired, ref_retired);
        check("next_fetch_state", 32'(state), 32'(classify(op) == C_SYS ? 3'd5 : 3'd0));
    endtask

    initial begin
        logic [4:0] op;
        bus.mem_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_strobes", 32'(observed()), 32'd0);
        check("reset_retired", retired, 32'd0);
        rst = 1'b0;

        insn(5'b01100, 0, 0, 1'b0);
        insn(5'b00000, 0, 2, 1'b0);
        insn(5'b11000, 0, 0, 1'b1);
        insn(5'b11000, 0, 0, 1'b0);

        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 4) == 0) op = 5'($urandom);
            else op = op_table[$urandom_range(0, 10)];
`ifdef MC_HALT_EN
            if (op == 5'b11100) op = 5'b00011;
`endif
            insn(op, $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end

        insn(5'b00100, 17, 0, 1'b0);
        insn(5'b01000, 1, 1, 1'b0);

        opcode = 5'b01000;
        build(5'b01000, 0, 5, 1'b0);
        run(3);
        bus.mem_ready = 1'b0;
        #1;
        check("pre_reset_mem_we", 32'({state, bus.mem_req, bus.mem_we}), 32'({3'd3, 1'b1, 1'b1}));
        rst = 1'b1;
        #1;
        check("midreset_strobes", 32'(observed()), 32'd0);
        check("midreset_retired", retired, 32'd0);
        ref_retired = 0;
        ref_sticky  = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;

        insn(5'b11011, 0, 0, 1'b0);
        insn(5'b11001, 1, 0, 1'b0);
        insn(5'b11100, 0, 0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
